// File: rtl/mpc_rsp_xbar_pkg.sv
// Shared types and sizing for the bank-to-channel response crossbar.
package mpc_types;

  localparam int unsigned NUM_BANK  = 4;
  localparam int unsigned NUM_CHN   = 3;
  localparam int unsigned CHN_ID_W  = 2;
  localparam int unsigned TAG_W     = 8;
  localparam int unsigned DATA_W    = 256;
  localparam int unsigned BANK_ID_W = 2;

  typedef struct packed {
    logic [CHN_ID_W-1:0] chan_id;
    logic [TAG_W-1:0]    tag;
    logic [DATA_W-1:0]   data;
  } rc_rsp_t;

  typedef struct packed {
    logic [BANK_ID_W-1:0] bank_id;
    logic [TAG_W-1:0]     tag;
    logic [DATA_W-1:0]    data;
  } channel_rsp_t;

endpackage

// File: rtl/mpc_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around;
// the pointer moves past the winner only when advance is asserted.
module mpc_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N-1:0]                           req,
  input  logic                                   advance,
  output logic [N-1:0]                           gnt_oh,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   gnt_idx
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic             found;
  int unsigned      k;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[IDX_W'(k)]) begin
        found               = 1'b1;
        gnt_oh[IDX_W'(k)]   = 1'b1;
        gnt_idx             = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : IDX_W'(gnt_idx + 1'b1);
    end
  end

endmodule

// File: rtl/mpc_rsp_xbar.sv
// Response crossbar: routes bank read completions to channels by chan_id,
// one round-robin arbiter and one registered output slice per channel.
module mpc_rsp_xbar
  import mpc_types::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BANK-1:0]   bank_rsp_valid,
  output logic [NUM_BANK-1:0]   bank_rsp_ready,
  input  rc_rsp_t               bank_rsp [NUM_BANK],
  output logic [NUM_CHN-1:0]    chn_rsp_valid,
  input  logic [NUM_CHN-1:0]    chn_rsp_ready,
  output channel_rsp_t          chn_rsp [NUM_CHN],
  output logic                  err_bad_chn
);

  logic [NUM_BANK-1:0]  req     [NUM_CHN];
  logic [NUM_BANK-1:0]  gnt_oh  [NUM_CHN];
  logic [BANK_ID_W-1:0] gnt_idx [NUM_CHN];
  logic [NUM_CHN-1:0]   load;
  logic [NUM_BANK-1:0]  bad;

  // Decode destinations; out-of-range ids are flagged for drop.
  always_comb begin
    bad = '0;
    for (int c = 0; c < NUM_CHN; c++) begin
      req[c] = '0;
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      bad[b] = bank_rsp_valid[b] && (bank_rsp[b].chan_id >= CHN_ID_W'(NUM_CHN));
      for (int c = 0; c < NUM_CHN; c++) begin
        req[c][b] = bank_rsp_valid[b] && (bank_rsp[b].chan_id == CHN_ID_W'(c));
      end
    end
  end

  for (genvar gc = 0; gc < NUM_CHN; gc++) begin : g_arb
    mpc_rr_arb #(.N(NUM_BANK)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[gc]),
      .advance (load[gc]),
      .gnt_oh  (gnt_oh[gc]),
      .gnt_idx (gnt_idx[gc])
    );
  end

  // A slice loads when empty or popping this cycle; dropped responses are always accepted.
  always_comb begin
    load           = '0;
    bank_rsp_ready = bad;
    for (int c = 0; c < NUM_CHN; c++) begin
      load[c]        = (|req[c]) && (!chn_rsp_valid[c] || chn_rsp_ready[c]);
      bank_rsp_ready = bank_rsp_ready | (gnt_oh[c] & {NUM_BANK{load[c]}});
    end
    bank_rsp_ready = bank_rsp_ready & {NUM_BANK{rst_n}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chn_rsp_valid <= '0;
      err_bad_chn   <= 1'b0;
      for (int c = 0; c < NUM_CHN; c++) begin
        chn_rsp[c] <= '0;
      end
    end else begin
      err_bad_chn <= |bad;
      for (int c = 0; c < NUM_CHN; c++) begin
        if (load[c]) begin
          chn_rsp_valid[c] <= 1'b1;
          chn_rsp[c]       <= '{bank_id: gnt_idx[c],
                                tag:     bank_rsp[gnt_idx[c]].tag,
                                data:    bank_rsp[gnt_idx[c]].data};
        end else if (chn_rsp_ready[c]) begin
          chn_rsp_valid[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpc_rsp_xbar.sv
// Directed self-checking bench for the bank-to-channel response crossbar.
module tb_mpc_rsp_xbar;
  import mpc_types::*;

  logic                clk;
  logic                rst_n;
  logic [NUM_BANK-1:0] bank_rsp_valid;
  logic [NUM_BANK-1:0] bank_rsp_ready;
  rc_rsp_t             bank_rsp [NUM_BANK];
  logic [NUM_CHN-1:0]  chn_rsp_valid;
  logic [NUM_CHN-1:0]  chn_rsp_ready;
  channel_rsp_t        chn_rsp [NUM_CHN];
  logic                err_bad_chn;

  int total;
  int bad;

  mpc_rsp_xbar dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bank_rsp_valid (bank_rsp_valid),
    .bank_rsp_ready (bank_rsp_ready),
    .bank_rsp       (bank_rsp),
    .chn_rsp_valid  (chn_rsp_valid),
    .chn_rsp_ready  (chn_rsp_ready),
    .chn_rsp        (chn_rsp),
    .err_bad_chn    (err_bad_chn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int b, input logic [1:0] ch, input logic [7:0] tg);
    bank_rsp_valid[b] = 1'b1;
    bank_rsp[b]       = '{chan_id: ch, tag: tg, data: {32{tg}}};
  endtask

  task automatic idle();
    bank_rsp_valid = '0;
    for (int b = 0; b < NUM_BANK; b++) bank_rsp[b] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    chn_rsp_ready = '1;
    idle();
    drive(0, 2'd0, 8'h11);
    #3;
    total++;
    if (bank_rsp_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_bank_ready got=%b want=0000", bank_rsp_ready);
    end
    total++;
    if (chn_rsp_valid !== 3'b000 || err_bad_chn !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got valid=%b err=%b want 000/0", chn_rsp_valid, err_bad_chn);
    end
    total++;
    if (chn_rsp[0] !== '0 || chn_rsp[1] !== '0 || chn_rsp[2] !== '0) begin
      bad++; $display("FAIL reset_payload got nonzero want zero");
    end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(2, 2'd1, 8'h5A);
    #1;
    total++;
    if (bank_rsp_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b want=0100", bank_rsp_ready);
    end
    tick();
    idle();
    total++;
    if (chn_rsp_valid !== 3'b010) begin
      bad++; $display("FAIL single_valid got=%b want=010", chn_rsp_valid);
    end
    total++;
    if (chn_rsp[1].bank_id !== 2'd2 || chn_rsp[1].tag !== 8'h5A || chn_rsp[1].data !== {32{8'h5A}}) begin
      bad++; $display("FAIL single_payload got bank=%0d tag=%h want bank=2 tag=5a",
                      chn_rsp[1].bank_id, chn_rsp[1].tag);
    end
    tick();
    total++;
    if (chn_rsp_valid !== 3'b000) begin
      bad++; $display("FAIL single_drain got=%b want=000", chn_rsp_valid);
    end
  endtask

  task automatic test_contention();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] exp;
    drive(0, 2'd0, 8'h20);
    drive(1, 2'd0, 8'h21);
    drive(3, 2'd0, 8'h23);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = 4'(1) << seq[k];
      total++;
      if (bank_rsp_ready !== exp) begin
        bad++; $display("FAIL contention_grant[%0d] got=%b want=%b", k, bank_rsp_ready, exp);
      end
      @(posedge clk);
      #1;
      total++;
      if (chn_rsp_valid[0] !== 1'b1 || chn_rsp[0].bank_id !== 2'(seq[k]) ||
          chn_rsp[0].tag !== 8'(8'h20 + seq[k])) begin
        bad++; $display("FAIL contention_out[%0d] got valid=%b bank=%0d want valid=1 bank=%0d",
                        k, chn_rsp_valid[0], chn_rsp[0].bank_id, seq[k]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         got  = 0;
    logic       full = 1'b0;
    logic [7:0] held = '0;
    logic       rdy;
    logic       exp_rdy;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      rdy = (cyc >= 5);
      chn_rsp_ready[2] = rdy;
      if (sent < 8) drive(1, 2'd2, 8'(8'h80 + sent));
      else idle();
      #1;
      exp_rdy = (sent < 8) && (!full || rdy);
      total++;
      if (bank_rsp_ready[1] !== exp_rdy) begin
        bad++; $display("FAIL bp_ready[cyc%0d] got=%b want=%b", cyc, bank_rsp_ready[1], exp_rdy);
      end
      total++;
      if (chn_rsp_valid[2] !== full || (full && chn_rsp[2].tag !== held)) begin
        bad++; $display("FAIL bp_slice[cyc%0d] got valid=%b tag=%h want valid=%b tag=%h",
                        cyc, chn_rsp_valid[2], chn_rsp[2].tag, full, held);
      end
      if (full && rdy) begin
        total++;
        if (held !== 8'(8'h80 + got)) begin
          bad++; $display("FAIL bp_order got=%h want=%h", held, 8'(8'h80 + got));
        end
        got++;
        full = 1'b0;
      end
      if (exp_rdy) begin
        held = 8'(8'h80 + sent);
        full = 1'b1;
        sent++;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (got != 8) begin
      bad++; $display("FAIL bp_count got=%0d want=8", got);
    end
    idle();
    chn_rsp_ready = '1;
    tick();
  endtask

  task automatic test_parallel();
    drive(0, 2'd2, 8'h30);
    drive(1, 2'd0, 8'h31);
    drive(2, 2'd1, 8'h32);
    #1;
    total++;
    if (bank_rsp_ready !== 4'b0111) begin
      bad++; $display("FAIL parallel_ready got=%b want=0111", bank_rsp_ready);
    end
    tick();
    idle();
    total++;
    if (chn_rsp_valid !== 3'b111) begin
      bad++; $display("FAIL parallel_valid got=%b want=111", chn_rsp_valid);
    end
    total++;
    if (chn_rsp[0].bank_id !== 2'd1 || chn_rsp[1].bank_id !== 2'd2 || chn_rsp[2].bank_id !== 2'd0) begin
      bad++; $display("FAIL parallel_route got %0d/%0d/%0d want 1/2/0",
                      chn_rsp[0].bank_id, chn_rsp[1].bank_id, chn_rsp[2].bank_id);
    end
    tick();
  endtask

  task automatic test_bad_id();
    drive(3, 2'd3, 8'h44);
    #1;
    total++;
    if (bank_rsp_ready !== 4'b1000 || err_bad_chn !== 1'b0) begin
      bad++; $display("FAIL badid_ready got ready=%b err=%b want 1000/0", bank_rsp_ready, err_bad_chn);
    end
    tick();
    idle();
    total++;
    if (err_bad_chn !== 1'b1 || chn_rsp_valid !== 3'b000) begin
      bad++; $display("FAIL badid_pulse got err=%b valid=%b want 1/000", err_bad_chn, chn_rsp_valid);
    end
    tick();
    total++;
    if (err_bad_chn !== 1'b0 || chn_rsp_valid !== 3'b000) begin
      bad++; $display("FAIL badid_end got err=%b valid=%b want 0/000", err_bad_chn, chn_rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    chn_rsp_ready = '0;
    drive(0, 2'd0, 8'h50);
    drive(1, 2'd1, 8'h51);
    tick();
    idle();
    total++;
    if (chn_rsp_valid !== 3'b011) begin
      bad++; $display("FAIL areset_fill got=%b want=011", chn_rsp_valid);
    end
    drive(2, 2'd2, 8'h52);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (chn_rsp_valid !== 3'b000 || chn_rsp[0] !== '0) begin
      bad++; $display("FAIL areset_clear got valid=%b want=000", chn_rsp_valid);
    end
    total++;
    if (bank_rsp_ready !== 4'b0000) begin
      bad++; $display("FAIL areset_ready got=%b want=0000", bank_rsp_ready);
    end
    idle();
    tick();
    rst_n = 1'b1;
    chn_rsp_ready = '1;
    tick();
    drive(0, 2'd1, 8'h60);
    drive(3, 2'd1, 8'h63);
    #1;
    total++;
    if (bank_rsp_ready !== 4'b0001) begin
      bad++; $display("FAIL areset_rr_first got=%b want=0001", bank_rsp_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (bank_rsp_ready !== 4'b1000) begin
      bad++; $display("FAIL areset_rr_second got=%b want=1000", bank_rsp_ready);
    end
    idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_parallel();
    test_bad_id();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
